// File: rtl/cache_fill_fsm.sv
// ----------------------------------------------------------------------------
// cache_fill_fsm
//
// Miss-handling engine sitting between a cache lookup stage and the shared,
// multi-cycle main memory. When the lookup reports a miss, the engine stalls
// the pipeline, streams one read request per cycle for every word of the
// aligned block, writes each returned word into the cache data array, and on
// the last return writes the tag/valid array and releases the stall.
//
// Ports
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   miss_detected       lookup missed this cycle (sampled only while idle)
//   miss_address        byte address of the miss (sampled with miss_detected)
//   fsm_busy            stall request to the pipeline
//   mem_rd_en/mem_addr  pipelined read request to memory
//   mem_data_valid/
//   mem_data            read return, strictly in request order
//   data_wr_en/
//   data_wr_addr/
//   data_wr_word        write port to the cache data array
//   tag_wr_en/
//   tag_wr_addr         write strobe and block base for the tag/valid array
//   fill_done           one-cycle pulse on the cycle the block completes
// ----------------------------------------------------------------------------
module cache_fill_fsm #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int BLOCK_WORDS = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] miss_address,
  output logic              fsm_busy,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_data_valid,
  input  logic [DATA_W-1:0] mem_data,
  output logic              data_wr_en,
  output logic [ADDR_W-1:0] data_wr_addr,
  output logic [DATA_W-1:0] data_wr_word,
  output logic              tag_wr_en,
  output logic [ADDR_W-1:0] tag_wr_addr,
  output logic              fill_done
);

  // Counters need one extra bit so "all words issued" (== BLOCK_WORDS) is
  // representable without wrapping back to zero.
  localparam int CNT_W = $clog2(BLOCK_WORDS) + 1;
  // Number of byte-offset bits inside one block (2 bytes per word).
  localparam int OFF_W = $clog2(2 * BLOCK_WORDS);

  localparam logic [CNT_W-1:0]  NUM_WORDS = CNT_W'(BLOCK_WORDS);
  localparam logic [CNT_W-1:0]  LAST_IDX  = CNT_W'(BLOCK_WORDS - 1);
  localparam logic [ADDR_W-1:0] OFF_MASK  = ADDR_W'((1 << OFF_W) - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    FILL = 2'b01
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [CNT_W-1:0]  issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]  recv_cnt_q, recv_cnt_d;

  // Block base: clear the byte-offset bits of the missing address.
  function automatic logic [ADDR_W-1:0] block_base(input logic [ADDR_W-1:0] addr);
    return addr & ~OFF_MASK;
  endfunction

  // Byte address of word idx within the block. Because base is aligned and
  // idx < BLOCK_WORDS, the sum never carries out of the block, so a block at
  // the top of the address space does not wrap.
  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [CNT_W-1:0]  idx);
    return base + (ADDR_W'(idx) << 1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      base_q      <= '0;
      issue_cnt_q <= '0;
      recv_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      issue_cnt_q <= issue_cnt_d;
      recv_cnt_q  <= recv_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    issue_cnt_d  = issue_cnt_q;
    recv_cnt_d   = recv_cnt_q;
    fsm_busy     = 1'b0;
    mem_rd_en    = 1'b0;
    mem_addr     = '0;
    data_wr_en   = 1'b0;
    data_wr_addr = '0;
    data_wr_word = '0;
    tag_wr_en    = 1'b0;
    tag_wr_addr  = '0;
    fill_done    = 1'b0;

    case (state_q)
      IDLE: begin
        // The stall must take effect in the miss cycle itself, so it is a
        // direct decode of the input. Gating with rst_n keeps it low while
        // reset is held, even if the lookup keeps reporting a miss.
        // Any mem_data_valid seen here is a stray return and is dropped.
        fsm_busy = miss_detected & rst_n;
        if (miss_detected) begin
          base_d      = block_base(miss_address);
          issue_cnt_d = '0;
          recv_cnt_d  = '0;
          state_d     = FILL;
        end
      end

      FILL: begin
        fsm_busy = 1'b1;

        // Issue side: one request per cycle until every word is requested.
        if (issue_cnt_q < NUM_WORDS) begin
          mem_rd_en   = 1'b1;
          mem_addr    = word_addr(base_q, issue_cnt_q);
          issue_cnt_d = issue_cnt_q + 1'b1;
        end

        // Receive side: independent of issue, paced only by mem_data_valid,
        // so any latency and any gaps between returns are tolerated.
        if (mem_data_valid) begin
          data_wr_en   = 1'b1;
          data_wr_addr = word_addr(base_q, recv_cnt_q);
          data_wr_word = mem_data;
          recv_cnt_d   = recv_cnt_q + 1'b1;
          // The final data write and the tag write share a cycle; the stall
          // is still asserted here and drops in the following IDLE cycle.
          if (recv_cnt_q == LAST_IDX) begin
            tag_wr_en   = 1'b1;
            tag_wr_addr = base_q;
            fill_done   = 1'b1;
            state_d     = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: doc/cache_fill_fsm.md
Name: cache_fill_fsm

Overview:
- Miss-handling engine between the pipeline's IF/MEM cache lookups and the shared multi-cycle main memory.
- On a cache miss it stalls the pipeline and fetches the aligned 8-word (16-byte) block from memory, one pipelined read request per cycle.
- It writes each returned word into the cache data array, then writes the tag array and releases the stall.
- One instance per cache (I-cache and D-cache), arbitrated upstream.

Parameters:
ADDR_W, 16, byte-address width.
DATA_W, 16, memory word width.
BLOCK_WORDS, 8, words per cache block; power of two; block size in bytes = 2*BLOCK_WORDS.

Ports:
clk  in  1  system clock, rising-edge.
rst_n  in  1  asynchronous active-low reset.
miss_detected  in  1  cache lookup missed this cycle; sampled only in IDLE.
miss_address  in  ADDR_W  byte address that missed; sampled with miss_detected.
fsm_busy  out  1  stall request to the pipeline.
mem_rd_en  out  1  read request to memory this cycle.
mem_addr  out  ADDR_W  byte address of the request.
mem_data_valid  in  1  memory returns a word this cycle, in request order.
mem_data  in  DATA_W  returned word.
data_wr_en  out  1  write strobe to the cache data array.
data_wr_addr  out  ADDR_W  byte address of the word being written.
data_wr_word  out  DATA_W  word to write; equals mem_data.
tag_wr_en  out  1  write strobe to the tag/valid array for the block at base address.
tag_wr_addr  out  ADDR_W  block base address for the tag write.
fill_done  out  1  one-cycle pulse when the block is complete.

Behaviour:
- States: IDLE and FILL, with a 2-bit state register. Registered fields: base (ADDR_W), issue_cnt (log2(BLOCK_WORDS)+1 bits), recv_cnt (same width).
- Reset, asynchronous on rst_n low:
  - state goes to IDLE; base, issue_cnt and recv_cnt go to 0.
  - Every output reads 0 for the duration of reset.
- IDLE:
  - fsm_busy = miss_detected (combinational) so the stall takes effect in the miss cycle.
  - On a clock edge with miss_detected=1: base <= miss_address with its low log2(2*BLOCK_WORDS) bits cleared; both counters <= 0; state goes to FILL.
  - mem_data_valid is ignored in IDLE, which discards stray returns after reset.
- FILL:
  - fsm_busy=1 for the whole state.
  - Issue side: while issue_cnt < BLOCK_WORDS, drive mem_rd_en=1 and mem_addr = base + 2*issue_cnt, and increment issue_cnt. Otherwise mem_rd_en=0 and mem_addr=0.
  - Receive side: on mem_data_valid=1, drive data_wr_en=1, data_wr_addr = base + 2*recv_cnt and data_wr_word = mem_data, and increment recv_cnt.
  - The issue and receive sides run independently; a valid return may coincide with an issue.
  - Completion: a valid return with recv_cnt = BLOCK_WORDS-1 asserts tag_wr_en=1, tag_wr_addr=base and fill_done=1 in that same cycle, together with the final data write. The next state is IDLE.
  - fsm_busy stays high through the completion cycle and drops in the following cycle, unless a new miss_detected arrives in IDLE.
- Address arithmetic is modulo 2^ADDR_W; a block at the top of memory does not wrap, because base is aligned.
- miss_detected and miss_address are ignored in FILL; base is never updated mid-fill.
- Memory latency is not assumed. Each return is counted only by mem_data_valid, so any latency of 1 cycle or more and any gaps between returns are tolerated.
- Reset asserted mid-fill aborts immediately:
  - No tag write occurs, leaving the block invalid.
  - Returns that arrive after reset are ignored in IDLE.
- Timing with a 4-cycle pipelined memory (requests in FILL cycles 0-7, data in cycles 4-11):
  - fill_done in FILL cycle 11.
  - fsm_busy high for 13 cycles: the miss cycle plus 12 FILL cycles.
- All outputs other than fsm_busy are combinational decodes of registered state and of mem_data_valid/mem_data. None are registered twice.

Test Plan:
- Reset, then miss_detected=1 with miss_address=0x1236 -> base=0x1230; mem_addr sequence 0x1230,0x1232,...,0x123E over 8 consecutive cycles; mem_rd_en low afterwards.
- 4-cycle memory model returning word = addr ^ 0xA5A5 -> 8 data writes at 0x1230..0x123E with matching data; tag_wr_en, tag_wr_addr=0x1230 and fill_done all in FILL cycle 11; fsm_busy high exactly 13 cycles.
- Memory with irregular gaps (valid on cycles 5,6,9,14,15,20,21,22) -> writes only on valid cycles, in order; completion on the 8th valid; no tag write earlier.
- miss_detected pulsed with address 0x4000 during an active fill of 0x1230 -> ignored; no request to 0x4000; fill of 0x1230 completes normally.
- rst_n dropped after the 5th data return, then released -> all outputs 0 immediately; no tag_wr_en; 3 late mem_data_valid pulses produce no data_wr_en; fsm_busy=0 with no miss.
- Back-to-back misses: miss_detected=1 at 0xFFF2 in the cycle after fill_done -> new fill with base=0xFFF0, last mem_addr=0xFFFE, no address wrap.
